// File: rtl/change_dispenser_pkg.sv
// Shared front-panel definitions: FSM state codes, default widths, and the
// coin-selection helper used by the dispenser and coin-acceptor FSMs.
package change_dispenser_pkg;

    localparam int unsigned DEF_AMT_W       = 3;
    localparam int unsigned DEF_ACK_TIMEOUT = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_D100 = 3'b001,
        S_D50  = 3'b010,
        S_REL  = 3'b011,
        S_DONE = 3'b100,
        S_ERR  = 3'b101
    } state_t;

    // Largest coin first: 100 while at least two units remain, then 50, then finish.
    function automatic state_t disp_state(input logic ge2, input logic eq1);
        if (ge2) begin
            return S_D100;
        end else if (eq1) begin
            return S_D50;
        end
        return S_DONE;
    endfunction

endpackage

// File: rtl/change_dispenser_rise_detect.sv
// Registered rising-edge detector for front-panel buttons; a level already high
// when reset releases must fall before it can produce a pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_prev;
    logic r_armed;
    logic r_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= in;
            r_armed <= r_armed | ~in;
            r_pulse <= in & ~r_prev & r_armed;
        end
    end

    assign pulse = r_pulse;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser FSM: pays out an amount in 100/50 coins through a hopper
// handshake, with an acknowledge timeout that parks the machine in ERR.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned AMT_W       = DEF_AMT_W,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             hop_ack,
    output logic             coin100,
    output logic             coin50,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remain,
    output logic [2:0]       state
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AMT_W-1:0] r_remain;
    logic [AMT_W-1:0] w_remain_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             w_sp;

    rise_detect u_start_rd (
        .clk   (clk),
        .rst   (rst),
        .in    (start),
        .pulse (w_sp)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            r_tmo    <= w_tmo_nxt;
        end
    end

    // Timeout counter defaults to zero, so it only survives while waiting in a dispense state.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_tmo_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_sp) begin
                    w_remain_nxt = amount;
                    w_state_nxt  = disp_state(amount >= AMT_W'(2), amount == AMT_W'(1));
                end
            end
            S_D100, S_D50: begin
                if (hop_ack) begin
                    if (r_state == S_D100) begin
                        w_remain_nxt = (r_remain >= AMT_W'(2)) ? r_remain - AMT_W'(2) : '0;
                    end else begin
                        w_remain_nxt = (r_remain != '0) ? r_remain - AMT_W'(1) : '0;
                    end
                    w_state_nxt = S_REL;
                end else if (r_tmo >= TMO_W'(ACK_TIMEOUT - 1)) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            S_REL: begin
                if (!hop_ack) begin
                    w_state_nxt = disp_state(r_remain >= AMT_W'(2), r_remain == AMT_W'(1));
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (w_sp) begin
                    w_state_nxt  = S_IDLE;
                    w_remain_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign coin100 = (r_state == S_D100);
    assign coin50  = (r_state == S_D50);
    assign done    = (r_state == S_DONE);
    assign err     = (r_state == S_ERR);
    assign busy    = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign remain  = r_remain;
    assign state   = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected coin/done/err events are queued
// when a payout is requested and popped as the DUT raises each output.
module tb_change_dispenser;

    localparam int unsigned AMT_W = 3;
    localparam logic [1:0] K100  = 2'd0;
    localparam logic [1:0] K50   = 2'd1;
    localparam logic [1:0] KDONE = 2'd2;
    localparam logic [1:0] KERR  = 2'd3;

    typedef struct packed {
        logic [1:0]       kind;
        logic [AMT_W-1:0] rem;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             hop_ack = 1'b0;
    logic             coin100;
    logic             coin50;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] remain;
    logic [2:0]       state;

    ev_t  sb[$];
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_done   = 0;
    int   cyc100   = 0;
    int   hop_mode = 0;
    logic hop_force = 1'b0;
    logic pend      = 1'b0;
    int   d0;

    change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(15)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .amount  (amount),
        .hop_ack (hop_ack),
        .coin100 (coin100),
        .coin50  (coin50),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .remain  (remain),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [AMT_W-1:0] r);
        ev_t e;
        e.kind = k;
        e.rem  = r;
        sb.push_back(e);
    endtask

    task automatic push_payout(input int unsigned amt);
        int unsigned r;
        r = amt;
        while (r >= 2) begin
            push(K100, AMT_W'(r));
            r -= 2;
        end
        if (r == 1) push(K50, AMT_W'(1));
        push(KDONE, '0);
    endtask

    task automatic press(input logic [AMT_W-1:0] a);
        @(negedge clk);
        start  = 1'b1;
        amount = a;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && state == 3'b000) break;
        end
        chk("drain_queue", sb.size(), 0);
        chk("drain_state", state, 0);
    endtask

    // Hopper model: 0 never acks, 1 acks one cycle after a request for one cycle, 2 follows hop_force.
    always @(negedge clk) begin
        case (hop_mode)
            0: begin
                hop_ack = 1'b0;
                pend    = 1'b0;
            end
            1: begin
                if (hop_ack) begin
                    hop_ack = 1'b0;
                end else if (coin100 || coin50) begin
                    if (pend) begin
                        hop_ack = 1'b1;
                        pend    = 1'b0;
                    end else begin
                        pend = 1'b1;
                    end
                end
            end
            default: begin
                hop_ack = hop_force;
                pend    = 1'b0;
            end
        endcase
    end

    always @(negedge clk) begin : mon
        logic       p100, p50, pdone, perr, hit;
        logic [1:0] k;
        ev_t        e;
        hit = 1'b0;
        k   = K100;
        if (coin100 && !p100) begin
            hit = 1'b1; k = K100;
        end else if (coin50 && !p50) begin
            hit = 1'b1; k = K50;
        end else if (done && !pdone) begin
            hit = 1'b1; k = KDONE;
        end else if (err && !perr) begin
            hit = 1'b1; k = KERR;
        end
        if (coin100) cyc100++;
        if (done && !pdone) n_done++;
        if (hit) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(k) + 32'd100, 32'(k));
            end else begin
                e = sb.pop_front();
                chk("ev_kind", k, e.kind);
                chk("ev_remain", remain, e.rem);
            end
        end
        p100  = coin100;
        p50   = coin50;
        pdone = done;
        perr  = err;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        amount = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_remain", remain, 0);
        chk("rst_coin100", coin100, 0);
        chk("rst_coin50", coin50, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // amount=5 normal payout
        hop_mode = 1;
        d0 = n_done;
        push_payout(5);
        press(3'd5);
        wait_idle(200);
        chk("p5_done_cnt", n_done - d0, 1);
        chk("p5_busy", busy, 0);
        chk("p5_remain", remain, 0);

        // amount=0: done one cycle after IDLE accepts sp
        d0 = n_done;
        push(KDONE, '0);
        @(negedge clk);
        start  = 1'b1;
        amount = '0;
        @(negedge clk);
        chk("p0_pre_done", done, 0);
        @(negedge clk);
        chk("p0_done", done, 1);
        chk("p0_state", state, 4);
        chk("p0_coin", {coin100, coin50}, 0);
        @(negedge clk);
        chk("p0_done_clr", done, 0);
        start = 1'b0;
        wait_idle(20);
        chk("p0_done_cnt", n_done - d0, 1);

        // Acknowledge timeout then clear with a start edge
        hop_mode = 0;
        cyc100 = 0;
        push(K100, 3'd2);
        push(KERR, 3'd2);
        press(3'd2);
        for (int i = 0; i < 40; i++) begin
            if (err) break;
            @(negedge clk);
        end
        chk("to_err", err, 1);
        chk("to_c100_cycles", cyc100, 15);
        chk("to_remain", remain, 2);
        chk("to_coin100", coin100, 0);
        chk("to_busy", busy, 0);
        press(3'd3);
        chk("clr_err", err, 0);
        chk("clr_state", state, 0);
        chk("clr_remain", remain, 0);
        wait_idle(10);

        // Second start during payout is ignored
        hop_mode = 1;
        d0 = n_done;
        push_payout(7);
        press(3'd7);
        repeat (4) @(negedge clk);
        chk("p7_busy_at_2nd", busy, 1);
        press(3'd1);
        wait_idle(300);
        repeat (10) @(negedge clk);
        chk("p7_state", state, 0);
        chk("p7_done_cnt", n_done - d0, 1);

        // hop_ack already high on entry to D100
        hop_mode  = 2;
        hop_force = 1'b1;
        @(negedge clk);
        cyc100 = 0;
        push_payout(3);
        press(3'd3);
        chk("pre_ack_state", state, 3);
        chk("pre_ack_remain", remain, 1);
        chk("pre_ack_c100", cyc100, 1);
        repeat (3) @(negedge clk);
        chk("pre_ack_hold_rel", state, 3);
        hop_force = 1'b0;
        hop_mode  = 1;
        wait_idle(100);

        // Reset mid-payout with start held through release
        hop_mode = 0;
        push(K50, 3'd1);
        press(3'd1);
        for (int i = 0; i < 20; i++) begin
            if (coin50) break;
            @(negedge clk);
        end
        chk("mid_coin50", coin50, 1);
        start = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_coin50", coin50, 0);
        chk("mid_rst_coin100", coin100, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_remain", remain, 0);
        chk("mid_rst_state", state, 0);
        sb.delete();
        d0 = n_done;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_start_state", state, 0);
        chk("held_start_done", n_done - d0, 0);
        start    = 1'b0;
        hop_mode = 1;
        repeat (2) @(negedge clk);
        push_payout(1);
        press(3'd1);
        wait_idle(100);
        chk("rearm_done_cnt", n_done - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
